bsg_counter_set_up_down_wrap: RTL and testbench



---
 rtl/bsg_counter_pkg.sv | 14 +
 rtl/bsg_counter_next_val.sv | 71 +++++++
 rtl/bsg_counter_set_up_down_wrap.sv | 74 +++++++
 tb/tb_bsg_counter_set_up_down_wrap.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_counter_pkg.sv
// Shared definitions for the bsg bounded counter family.
// Mode encodings and a width helper reused by sibling counters.
package bsg_counter_pkg;

  localparam int e_counter_wrap = 1;
  localparam int e_counter_sat  = 0;

  // Bits needed to hold 0..max_val inclusive (never less than 1).
  function automatic int counter_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_counter_next_val.sv
// Next-state logic for the bounded set/up/down counter.
// Produces next count plus wrap/saturate event and clamp flags.
module bsg_counter_next_val
  import bsg_counter_pkg::*;
#(
  parameter int max_val_p = 50,
  parameter int wrap_p    = 1,
  parameter int width_p   = 6
) (
  input  logic [width_p-1:0] count,
  input  logic               up,
  input  logic               down,
  input  logic               set,
  input  logic [width_p-1:0] val,
  output logic [width_p-1:0] next,
  output logic               event_hit,
  output logic               clamp
);

  localparam logic [width_p:0]   max_w  = (width_p+1)'(max_val_p);
  localparam logic [width_p-1:0] max_lo = width_p'(max_val_p);
  localparam logic [width_p-1:0] one    = width_p'(1);
  localparam logic               wrap   = (wrap_p == e_counter_wrap);

  logic [width_p:0] count_w;
  logic [width_p:0] val_w;
  logic             inc;
  logic             dec;

  assign count_w = {1'b0, count};
  assign val_w   = {1'b0, val};
  assign inc     = !set && up && !down;
  assign dec     = !set && down && !up;

  // Select load, bounded increment, bounded decrement or hold.
  always_comb begin
    next      = count;
    event_hit = 1'b0;
    clamp     = 1'b0;
    unique case (1'b1)
      set: begin
        if (val_w > max_w) begin
          next  = max_lo;
          clamp = 1'b1;
        end else begin
          next = val;
        end
      end
      inc: begin
        if (count_w >= max_w) begin
          next      = wrap ? '0 : max_lo;
          event_hit = 1'b1;
        end else begin
          next = count + one;
        end
      end
      dec: begin
        if (count_w == '0) begin
          next      = wrap ? max_lo : '0;
          event_hit = 1'b1;
        end else begin
          next = count - one;
        end
      end
      default: begin
        next = count;
      end
    endcase
  end

endmodule

// File: rtl/bsg_counter_set_up_down_wrap.sv
// Bounded 0..max_val_p counter with load, up/down and wrap/saturate.
// Holds the count, event and clamp registers plus flag decode.
module bsg_counter_set_up_down_wrap
  import bsg_counter_pkg::*;
#(
  parameter int max_val_p    = 50,
  parameter int init_val_p   = 0,
  parameter int wrap_p       = 1,
  localparam int ptr_width_lp = counter_width(max_val_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    set_i,
  input  logic [ptr_width_lp-1:0] val_i,
  input  logic                    up_i,
  input  logic                    down_i,
  output logic [ptr_width_lp-1:0] count_o,
  output logic                    zero_o,
  output logic                    max_o,
  output logic                    event_o,
  output logic                    clamp_o
);

  localparam logic [ptr_width_lp:0] max_w =
    (ptr_width_lp+1)'(max_val_p);
  localparam logic [ptr_width_lp-1:0] init_lo =
    ptr_width_lp'(init_val_p);

  if (max_val_p < 1) begin : g_bad_max
    $error("max_val_p must be at least 1");
  end
  if (init_val_p < 0 || init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must lie in 0..max_val_p");
  end
  if (wrap_p != e_counter_wrap && wrap_p != e_counter_sat) begin : g_bad_wrap
    $error("wrap_p must be 0 or 1");
  end

  logic [ptr_width_lp-1:0] next;
  logic                    event_hit;
  logic                    clamp;

  bsg_counter_next_val #(
    .max_val_p (max_val_p),
    .wrap_p    (wrap_p),
    .width_p   (ptr_width_lp)
  ) u_next (
    .count     (count_o),
    .up        (up_i),
    .down      (down_i),
    .set       (set_i),
    .val       (val_i),
    .next      (next),
    .event_hit (event_hit),
    .clamp     (clamp)
  );

  // Count and pulse registers; reset wins over any pending update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= init_lo;
      event_o <= 1'b0;
      clamp_o <= 1'b0;
    end else begin
      count_o <= next;
      event_o <= event_hit;
      clamp_o <= clamp;
    end
  end

  assign zero_o = (count_o == '0);
  assign max_o  = ({1'b0, count_o} == max_w);

endmodule

// File: tb/tb_bsg_counter_set_up_down_wrap.sv
// Directed bench for bsg_counter_set_up_down_wrap.
// Four configurations share one stimulus stream.
module tb_bsg_counter_set_up_down_wrap;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set = 1'b0;
  logic [5:0] val = '0;
  logic       up = 1'b0;
  logic       down = 1'b0;

  logic [5:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic       a_z, a_m, a_e, a_c;
  logic       b_z, b_m, b_e, b_c;
  logic       c_z, c_m, c_e, c_c;
  logic       d_z, d_m, d_e, d_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: 50/0/wrap  b: 50/0/sat  c: 50/7/wrap  d: 63/0/wrap
  bsg_counter_set_up_down_wrap #(
    .max_val_p(50), .init_val_p(0), .wrap_p(1)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .set_i(set), .val_i(val),
    .up_i(up), .down_i(down), .count_o(a_cnt), .zero_o(a_z),
    .max_o(a_m), .event_o(a_e), .clamp_o(a_c)
  );

  bsg_counter_set_up_down_wrap #(
    .max_val_p(50), .init_val_p(0), .wrap_p(0)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .set_i(set), .val_i(val),
    .up_i(up), .down_i(down), .count_o(b_cnt), .zero_o(b_z),
    .max_o(b_m), .event_o(b_e), .clamp_o(b_c)
  );

  bsg_counter_set_up_down_wrap #(
    .max_val_p(50), .init_val_p(7), .wrap_p(1)
  ) dut_c (
    .clk_i(clk), .reset_i(reset), .set_i(set), .val_i(val),
    .up_i(up), .down_i(down), .count_o(c_cnt), .zero_o(c_z),
    .max_o(c_m), .event_o(c_e), .clamp_o(c_c)
  );

  bsg_counter_set_up_down_wrap #(
    .max_val_p(63), .init_val_p(0), .wrap_p(1)
  ) dut_d (
    .clk_i(clk), .reset_i(reset), .set_i(set), .val_i(val),
    .up_i(up), .down_i(down), .count_o(d_cnt), .zero_o(d_z),
    .max_o(d_m), .event_o(d_e), .clamp_o(d_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_a_cnt", 32'(a_cnt), 0);
    chk("rst_a_zero", 32'(a_z), 1);
    chk("rst_a_max", 32'(a_m), 0);
    chk("rst_a_evt", 32'(a_e), 0);
    chk("rst_a_clamp", 32'(a_c), 0);
    chk("rst_c_cnt", 32'(c_cnt), 7);

    up = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    chk("up50_a_cnt", 32'(a_cnt), 50);
    chk("up50_a_max", 32'(a_m), 1);
    chk("up50_a_evt", 32'(a_e), 0);
    chk("up50_b_cnt", 32'(b_cnt), 50);
    chk("up50_c_cnt", 32'(c_cnt), 6);
    chk("up50_d_cnt", 32'(d_cnt), 50);
    chk("up50_d_max", 32'(d_m), 0);

    cyc();
    chk("wrap_a_cnt", 32'(a_cnt), 0);
    chk("wrap_a_evt", 32'(a_e), 1);
    chk("wrap_a_zero", 32'(a_z), 1);
    chk("sat_b_cnt", 32'(b_cnt), 50);
    chk("sat_b_evt", 32'(b_e), 1);
    chk("up_d_cnt", 32'(d_cnt), 51);
    chk("up_d_evt", 32'(d_e), 0);
    up = 1'b0;
    cyc();
    chk("pulse_a_evt", 32'(a_e), 0);
    chk("pulse_b_evt", 32'(b_e), 0);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    down = 1'b1;
    cyc();
    down = 1'b0;
    chk("dn_a_cnt", 32'(a_cnt), 50);
    chk("dn_a_evt", 32'(a_e), 1);
    chk("dn_a_max", 32'(a_m), 1);
    chk("dn_b_cnt", 32'(b_cnt), 0);
    chk("dn_b_evt", 32'(b_e), 1);
    chk("dn_b_zero", 32'(b_z), 1);
    chk("dn_d_cnt", 32'(d_cnt), 63);
    chk("dn_d_max", 32'(d_m), 1);
    cyc();
    chk("dn_a_evt_off", 32'(a_e), 0);
    chk("dn_b_cnt_hold", 32'(b_cnt), 0);

    set = 1'b1;
    val = 6'd63;
    cyc();
    chk("set63_a_cnt", 32'(a_cnt), 50);
    chk("set63_a_clamp", 32'(a_c), 1);
    chk("set63_d_cnt", 32'(d_cnt), 63);
    chk("set63_d_clamp", 32'(d_c), 0);
    val = 6'd17;
    up = 1'b1;
    cyc();
    chk("set17_a_cnt", 32'(a_cnt), 17);
    chk("set17_a_clamp", 32'(a_c), 0);
    chk("set17_a_evt", 32'(a_e), 0);

    val = 6'd30;
    up = 1'b0;
    cyc();
    set = 1'b0;
    up = 1'b1;
    down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("updn_a_cnt", 32'(a_cnt), 30);
      chk("updn_a_evt", 32'(a_e), 0);
    end
    down = 1'b0;
    up = 1'b0;

    set = 1'b1;
    val = 6'd50;
    cyc();
    set = 1'b0;
    chk("pre_c_cnt", 32'(c_cnt), 50);
    up = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    up = 1'b0;
    chk("rstwrap_c_cnt", 32'(c_cnt), 7);
    chk("rstwrap_c_evt", 32'(c_e), 0);
    chk("rstwrap_a_cnt", 32'(a_cnt), 0);
    cyc();
    chk("rstwrap_c_evt2", 32'(c_e), 0);
    chk("rstwrap_c_hold", 32'(c_cnt), 7);

    set = 1'b1;
    val = 6'd63;
    cyc();
    set = 1'b0;
    up = 1'b1;
    cyc();
    up = 1'b0;
    chk("d_wrap_cnt", 32'(d_cnt), 0);
    chk("d_wrap_evt", 32'(d_e), 1);
    chk("d_wrap_zero", 32'(d_z), 1);
    chk("d_wrap_clamp", 32'(d_c), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
